// File: rtl/median_window_feeder_pkg.sv
// Shared types and helpers for the median filter window feeder.
package median_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int WIN_SIZE = 9;
  localparam int PIX_W    = 8;

  typedef logic [PIX_W-1:0] window_t [3][3];

  // Row of the window element sent at serial position idx (row-major order).
  function automatic logic [1:0] win_row(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: win_row = 2'd0;
      4'd3, 4'd4, 4'd5: win_row = 2'd1;
      default:          win_row = 2'd2;
    endcase
  endfunction

  // Column of the window element sent at serial position idx.
  function automatic logic [1:0] win_col(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: win_col = 2'd0;
      4'd1, 4'd4, 4'd7: win_col = 2'd1;
      default:          win_col = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/median_window_feeder_line_buffer_2x.sv
// Two cascaded line buffers: MID is the previous row, TOP the row before it.
module line_buffer_2x
  import median_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          CLK,
  input  logic          WE,
  input  logic [AW-1:0] ADDR,
  input  logic [W-1:0]  DIN,
  output logic [W-1:0]  TOP,
  output logic [W-1:0]  MID
);

  logic [W-1:0] lb0_r [DEPTH];
  logic [W-1:0] lb1_r [DEPTH];

  assign TOP = lb1_r[ADDR];
  assign MID = lb0_r[ADDR];

  // Column write: the older row moves down into LB1, the new pixel into LB0.
  always_ff @(posedge CLK) begin
    if (WE) begin
      lb1_r[ADDR] <= lb0_r[ADDR];
      lb0_r[ADDR] <= DIN;
    end
  end

endmodule

// File: rtl/median_window_feeder.sv
// Raster-to-3x3 window feeder: serializes each interior neighbourhood to the
// median core and returns the captured median on a valid/ready port.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int W       = 8,
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] IN_DATA,
  input  logic         IN_VALID,
  input  logic         IN_SOF,
  output logic         IN_READY,
  output logic [W-1:0] MED_DI,
  output logic         MED_DSI,
  input  logic [W-1:0] MED_DO,
  input  logic         MED_DSO,
  output logic [W-1:0] RES_DATA,
  output logic         RES_VALID,
  input  logic         RES_READY,
  output logic         ERR
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT);

  state_t        state_r, state_s;
  logic [CW-1:0] col_r, col_eff_s, col_nxt_s;
  logic [RW-1:0] row_r, row_eff_s, row_nxt_s;
  logic [TW-1:0] tmo_r, tmo_inc_s;
  logic [3:0]    idx_r;
  logic [W-1:0]  win_r [3][3];
  logic [W-1:0]  win_s [3][3];
  logic [W-1:0]  top_s, mid_s;
  logic          accept_s, complete_s, res_hs_s, hs_seen_r;
  logic          in_ready_r, med_dsi_r, res_valid_r, err_r;
  logic [W-1:0]  med_di_r, res_data_r;

  assign accept_s  = IN_VALID & in_ready_r;
  assign res_hs_s  = res_valid_r & RES_READY;
  assign tmo_inc_s = tmo_r + TW'(1);

  assign IN_READY  = in_ready_r;
  assign MED_DI    = med_di_r;
  assign MED_DSI   = med_dsi_r;
  assign RES_DATA  = res_data_r;
  assign RES_VALID = res_valid_r;
  assign ERR       = err_r;

  line_buffer_2x #(.W(W), .DEPTH(WIDTH), .AW(CW)) u_lb (
    .CLK  (CLK),
    .WE   (accept_s),
    .ADDR (col_eff_s),
    .DIN  (IN_DATA),
    .TOP  (top_s),
    .MID  (mid_s)
  );

  // Raster position of the pixel on the input port (SOF forces the origin) and its successor.
  always_comb begin
    col_eff_s  = col_r;
    row_eff_s  = row_r;
    col_nxt_s  = col_r;
    row_nxt_s  = row_r;
    complete_s = 1'b0;
    if (IN_SOF) begin
      col_eff_s = {CW{1'b0}};
      row_eff_s = {RW{1'b0}};
    end else begin
      col_eff_s = col_r;
      row_eff_s = row_r;
    end
    if (col_eff_s == COL_LAST) begin
      col_nxt_s = {CW{1'b0}};
      if (row_eff_s == ROW_LAST) begin
        row_nxt_s = {RW{1'b0}};
      end else begin
        row_nxt_s = row_eff_s + RW'(1);
      end
    end else begin
      col_nxt_s = col_eff_s + CW'(1);
      row_nxt_s = row_eff_s;
    end
    complete_s = (col_eff_s >= CW'(2)) && (row_eff_s >= RW'(2));
  end

  // Window after the incoming column is shifted in at the right edge.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_s[r][0] = win_r[r][1];
      win_s[r][1] = win_r[r][2];
    end
    win_s[0][2] = top_s;
    win_s[1][2] = mid_s;
    win_s[2][2] = IN_DATA;
  end

  // Next-state decision for the feeder sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && complete_s) begin
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (idx_r == 4'(WIN_SIZE)) begin
          state_s = WAIT;
        end else begin
          state_s = SEND;
        end
      end
      WAIT: begin
        if (MED_DSO) begin
          state_s = OUT;
        end else if (tmo_inc_s == TMO_LAST) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      OUT: begin
        // Leave only once the result was taken and the core has dropped DSO.
        if ((hs_seen_r || res_hs_s) && !MED_DSO) begin
          state_s = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Window shift register; contents are don't-care until a window completes.
  always_ff @(posedge CLK) begin
    if (accept_s) begin
      win_r <= win_s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      col_r       <= {CW{1'b0}};
      row_r       <= {RW{1'b0}};
      tmo_r       <= {TW{1'b0}};
      idx_r       <= 4'd0;
      hs_seen_r   <= 1'b0;
      med_di_r    <= {W{1'b0}};
      med_dsi_r   <= 1'b0;
      res_data_r  <= {W{1'b0}};
      res_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == IDLE);
      if (accept_s) begin
        col_r <= col_nxt_s;
        row_r <= row_nxt_s;
      end
      case (state_r)
        IDLE: begin
          hs_seen_r <= 1'b0;
          if (accept_s && complete_s) begin
            med_dsi_r <= 1'b1;
            med_di_r  <= win_s[0][0];
            idx_r     <= 4'd1;
          end
        end
        SEND: begin
          if (idx_r == 4'(WIN_SIZE)) begin
            med_dsi_r <= 1'b0;
            med_di_r  <= {W{1'b0}};
            idx_r     <= 4'd0;
            // The last DSI cycle already counts as the first timeout cycle.
            tmo_r     <= TW'(1);
          end else begin
            med_di_r <= win_r[win_row(idx_r)][win_col(idx_r)];
            idx_r    <= idx_r + 4'd1;
          end
        end
        WAIT: begin
          if (MED_DSO) begin
            res_data_r  <= MED_DO;
            res_valid_r <= 1'b1;
            hs_seen_r   <= 1'b0;
          end else if (tmo_inc_s == TMO_LAST) begin
            err_r <= 1'b1;
          end else begin
            tmo_r <= tmo_inc_s;
          end
        end
        OUT: begin
          if (res_hs_s) begin
            res_valid_r <= 1'b0;
            hs_seen_r   <= 1'b1;
          end
        end
        default: begin
          med_dsi_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed/random bench for median_window_feeder on a 4x4 image with a
// behavioural median core and a frame-level expected-result model.
module tb_median_window_feeder;

  localparam int PW  = 8;
  localparam int IW  = 4;
  localparam int IH  = 4;
  localparam int TMO = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [PW-1:0] IN_DATA = '0;
  logic          IN_VALID = 1'b0;
  logic          IN_SOF = 1'b0;
  logic          IN_READY;
  logic [PW-1:0] MED_DI;
  logic          MED_DSI;
  logic [PW-1:0] MED_DO = '0;
  logic          MED_DSO = 1'b0;
  logic [PW-1:0] RES_DATA;
  logic          RES_VALID;
  logic          RES_READY = 1'b0;
  logic          ERR;

  median_window_feeder #(.W(PW), .WIDTH(IW), .HEIGHT(IH), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_SOF(IN_SOF),
    .IN_READY(IN_READY), .MED_DI(MED_DI), .MED_DSI(MED_DSI), .MED_DO(MED_DO),
    .MED_DSO(MED_DSO), .RES_DATA(RES_DATA), .RES_VALID(RES_VALID),
    .RES_READY(RES_READY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cq[$];
  int di_log[$];
  int burst_len_q[$];
  int res_q[$];
  int exp_q[$];
  int img[IW*IH];
  int nf[20];
  int delay = 0;
  int hold = 0;
  int core_med = 0;
  bit core_en = 1'b1;
  int ramp_res[4] = '{5, 6, 9, 10};
  int ramp_di[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  function automatic int med9(input int v[$]);
    int s[$];
    s = v;
    s.sort();
    return s[4];
  endfunction

  // Behavioural median core: gathers a 9-pixel burst, answers 3 cycles after DSI falls, DSO for 4 cycles.
  always @(negedge CLK) begin
    if (hold > 0) begin
      hold--;
      if (hold == 0) MED_DSO = 1'b0;
    end
    if (delay > 0) begin
      delay--;
      if (delay == 0) begin
        MED_DO  = PW'(core_med);
        MED_DSO = 1'b1;
        hold    = 4;
      end
    end
    if (MED_DSI === 1'b1) begin
      cq.push_back(int'(MED_DI));
      di_log.push_back(int'(MED_DI));
    end else if (cq.size() > 0) begin
      burst_len_q.push_back(cq.size());
      if (cq.size() == 9 && core_en) begin
        core_med = med9(cq);
        delay = 3;
      end
      cq.delete();
    end
  end

  // Result monitor.
  always @(posedge CLK) begin
    if (RST === 1'b0 && RES_VALID === 1'b1 && RES_READY === 1'b1) res_q.push_back(int'(RES_DATA));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_pix(input int d, input bit sof);
    int n;
    n = 0;
    IN_DATA = PW'(d);
    IN_SOF = sof;
    IN_VALID = 1'b1;
    while (IN_READY !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("in_ready_wait", 32'(n), 32'(0));
    tick();
    IN_VALID = 1'b0;
    IN_SOF = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (IN_READY !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 300), 32'(1));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  // Expected medians of every interior 3x3 neighbourhood of img, in raster order.
  task automatic build_exp();
    exp_q.delete();
    for (int r = 2; r < IH; r++) begin
      for (int c = 2; c < IW; c++) begin
        int w[$];
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            w.push_back(img[(r - 2 + dr) * IW + (c - 2 + dc)]);
        exp_q.push_back(med9(w));
      end
    end
  endtask

  task automatic run_frame(input string tag);
    for (int i = 0; i < IW * IH; i++) begin
      push_pix(img[i], i == 0);
      if (i == 2 * IW + 2) begin
        chk({tag, "_dsi_start"}, 32'(MED_DSI), 32'(1));
        chk({tag, "_di_first"}, 32'(MED_DI), 32'(img[0]));
      end
    end
    wait_idle({tag, "_drain"});
  endtask

  task automatic cmp_res(input string tag);
    chk({tag, "_count"}, 32'(res_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < res_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_res%0d", tag, i), 32'(res_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int n;
    int k;
    bit seen;
    int w[$];

    // Reset with random inputs.
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IN_DATA = PW'($urandom);
      IN_VALID = 1'($urandom);
      IN_SOF = 1'($urandom);
      RES_READY = 1'($urandom);
      tick();
      chk("rst_in_ready", 32'(IN_READY), 32'(0));
      chk("rst_med_di", 32'(MED_DI), 32'(0));
      chk("rst_med_dsi", 32'(MED_DSI), 32'(0));
      chk("rst_res_data", 32'(RES_DATA), 32'(0));
      chk("rst_res_valid", 32'(RES_VALID), 32'(0));
      chk("rst_err", 32'(ERR), 32'(0));
    end
    RST = 1'b0;
    IN_VALID = 1'b0;
    IN_SOF = 1'b0;
    RES_READY = 1'b1;
    tick();
    chk("rel_in_ready", 32'(IN_READY), 32'(1));

    // Ramp frame.
    res_q.delete(); di_log.delete(); burst_len_q.delete();
    for (int i = 0; i < IW * IH; i++) img[i] = i;
    build_exp();
    run_frame("ramp");
    cmp_res("ramp_model");
    for (int i = 0; i < 4 && i < res_q.size(); i++)
      chk($sformatf("ramp_const%0d", i), 32'(res_q[i]), 32'(ramp_res[i]));
    chk("ramp_bursts", 32'(burst_len_q.size()), 32'(4));
    for (int i = 0; i < burst_len_q.size(); i++)
      chk($sformatf("ramp_burst_len%0d", i), 32'(burst_len_q[i]), 32'(9));
    chk("ramp_di_total", 32'(di_log.size()), 32'(36));
    for (int i = 0; i < 9 && i < di_log.size(); i++)
      chk($sformatf("ramp_di%0d", i), 32'(di_log[i]), 32'(ramp_di[i]));

    // Random frame with result backpressure.
    res_q.delete();
    for (int i = 0; i < IW * IH; i++) img[i] = $urandom_range(0, 255);
    build_exp();
    RES_READY = 1'b0;
    for (int i = 0; i <= 2 * IW + 2; i++) push_pix(img[i], i == 0);
    n = 0;
    while (RES_VALID !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("bp_valid_wait", 32'(n < 100), 32'(1));
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 32'(RES_VALID), 32'(1));
      chk("bp_data", 32'(RES_DATA), 32'(exp_q[0]));
      chk("bp_in_ready", 32'(IN_READY), 32'(0));
      tick();
    end
    RES_READY = 1'b1;
    for (int i = 2 * IW + 3; i < IW * IH; i++) push_pix(img[i], 1'b0);
    wait_idle("bp_drain");
    cmp_res("bp");

    // SOF in the middle of a frame restarts the raster position.
    res_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push_pix($urandom_range(0, 255), i == 0);
      if (MED_DSI === 1'b1) seen = 1'b1;
    end
    chk("sof_border_quiet", 32'(seen), 32'(0));
    k = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      nf[i] = $urandom_range(0, 255);
      push_pix(nf[i], i == 0);
      k++;
      if (MED_DSI === 1'b1) seen = 1'b1;
    end
    chk("sof_accepts", 32'(k), 32'(2 * IW + 3));
    wait_idle("sof_drain");
    w.delete();
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w.push_back(nf[dr * IW + dc]);
    chk("sof_res_count", 32'(res_q.size()), 32'(1));
    if (res_q.size() > 0) chk("sof_res", 32'(res_q[0]), 32'(med9(w)));

    // Core never answers: timeout sets the sticky error.
    core_en = 1'b0;
    do_reset();
    res_q.delete();
    for (int i = 0; i <= 2 * IW + 2; i++) push_pix(i, i == 0);
    n = 0;
    while (MED_DSI === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("tmo_dsi_cycles", 32'(n), 32'(9));
    n = 1;
    while (ERR !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_err_delay", 32'(n), 32'(TMO));
    chk("tmo_no_valid", 32'(RES_VALID), 32'(0));
    tick();
    chk("tmo_in_ready", 32'(IN_READY), 32'(1));
    chk("tmo_err_next", 32'(ERR), 32'(1));
    repeat (5) tick();
    chk("tmo_err_sticky", 32'(ERR), 32'(1));
    chk("tmo_no_result", 32'(res_q.size()), 32'(0));
    do_reset();
    chk("tmo_err_cleared", 32'(ERR), 32'(0));
    core_en = 1'b1;

    // Reset in the middle of SEND.
    res_q.delete(); burst_len_q.delete();
    for (int i = 0; i <= 2 * IW + 2; i++) push_pix(i, i == 0);
    chk("abort_dsi1", 32'(MED_DSI), 32'(1));
    repeat (3) tick();
    chk("abort_dsi4", 32'(MED_DSI), 32'(1));
    RST = 1'b1;
    tick();
    chk("abort_dsi_low", 32'(MED_DSI), 32'(0));
    chk("abort_valid_low", 32'(RES_VALID), 32'(0));
    RST = 1'b0;
    tick();
    chk("abort_in_ready", 32'(IN_READY), 32'(1));
    repeat (10) tick();
    chk("abort_no_result", 32'(res_q.size()), 32'(0));
    chk("abort_burst_len", 32'(burst_len_q.size() > 0 ? burst_len_q[burst_len_q.size() - 1] : -1), 32'(4));
    res_q.delete();
    for (int i = 0; i < IW * IH; i++) img[i] = i;
    build_exp();
    run_frame("reramp");
    chk("reramp_count", 32'(res_q.size()), 32'(4));
    for (int i = 0; i < 4 && i < res_q.size(); i++)
      chk($sformatf("reramp_const%0d", i), 32'(res_q[i]), 32'(ramp_res[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
